// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between the input ports, the priority register and the
// round-robin grant controller.
interface rr_grant_ctrl_if #(
   parameter int PORTS = 4
);
   logic [PORTS-1:0] priority_order_i;
   logic [PORTS-1:0] req_i;
   logic [PORTS-1:0] tail_i;
   logic             out_ready_i;
   logic [PORTS-1:0] grant_o;
   logic [1:0]       grant_id_o;
   logic             change_order_o;
   logic             busy_o;

   // Requester/priority side drives requests and observes grants.
   modport master (
      output priority_order_i, req_i, tail_i, out_ready_i,
      input  grant_o, grant_id_o, change_order_o, busy_o
   );

   // Grant controller side.
   modport slave (
      input  priority_order_i, req_i, tail_i, out_ready_i,
      output grant_o, grant_id_o, change_order_o, busy_o
   );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: locks one requester per packet and pulses
// change_order_o once after the tail flit so the priority register rotates.
//
// state   | meaning
// IDLE    | no grant; arbitrate among req_i starting at the priority index
// LOCK    | grant held until tail transfer (or abort when ABORT_EN)
// RELEASE | one cycle, grant cleared, change_order_o high, no arbitration
module rr_grant_ctrl #(
   parameter int PORTS    = 4,
   parameter bit ABORT_EN = 1'b1
) (
   input logic           clk,
   input logic           reset,
   rr_grant_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCK    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PORTS-1:0] grant_q, grant_d;
   logic [1:0]       grant_id_q, grant_id_d;
   logic             change_q, change_d;
   logic             busy_q, busy_d;

   logic [1:0]       prio_idx;
   logic [1:0]       cand;
   logic [1:0]       win_idx;
   logic             win_found;
   logic             g_req;
   logic             g_tail;
   logic             xfer;
   logic             release_pkt;

   // A malformed priority vector falls back to port 0 rather than stalling.
   always_comb begin
      prio_idx = 2'd0;
      case (bus.priority_order_i)
         4'b0001: prio_idx = 2'd0;
         4'b0010: prio_idx = 2'd1;
         4'b0100: prio_idx = 2'd2;
         4'b1000: prio_idx = 2'd3;
         default: prio_idx = 2'd0;
      endcase
   end

   always_comb begin
      win_idx   = 2'd0;
      win_found = 1'b0;
      cand      = 2'd0;
      for (int i = 0; i < PORTS; i++) begin
         cand = prio_idx + 2'(i);
         if (!win_found && bus.req_i[cand]) begin
            win_idx   = cand;
            win_found = 1'b1;
         end
      end
   end

   assign g_req       = bus.req_i[grant_id_q];
   assign g_tail      = bus.tail_i[grant_id_q];
   assign xfer        = g_req & bus.out_ready_i;
   assign release_pkt = (xfer & g_tail) | (ABORT_EN & ~g_req);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      change_d   = 1'b0;
      busy_d     = busy_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d    = LOCK;
               grant_d    = PORTS'(1) << win_idx;
               grant_id_d = win_idx;
               busy_d     = 1'b1;
            end else begin
               grant_d    = '0;
               grant_id_d = 2'd0;
               busy_d     = 1'b0;
            end
         end
         LOCK: begin
            busy_d = 1'b1;
            if (release_pkt) begin
               state_d    = RELEASE;
               grant_d    = '0;
               grant_id_d = 2'd0;
               change_d   = 1'b1;
            end
         end
         RELEASE: begin
            // Priority input is stale this cycle, so no arbitration here.
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = 2'd0;
            busy_d     = 1'b0;
         end
         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = 2'd0;
            busy_d     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_id_q <= 2'd0;
         change_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         change_q   <= change_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.grant_o        = grant_q;
   assign bus.grant_id_o     = grant_id_q;
   assign bus.change_order_o = change_q;
   assign bus.busy_o         = busy_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl: one instance with abort enabled, one without.
module tb_rr_grant_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] prio = 4'b0001;
   logic [3:0] req = 4'b0000;
   logic [3:0] tail = 4'b0000;
   logic       ready = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] exp_seq [5];
   logic [3:0] prev_grant;

   rr_grant_ctrl_if #(.PORTS(4)) if_a ();
   rr_grant_ctrl_if #(.PORTS(4)) if_n ();

   assign if_a.priority_order_i = prio;
   assign if_a.req_i            = req;
   assign if_a.tail_i           = tail;
   assign if_a.out_ready_i      = ready;
   assign if_n.priority_order_i = prio;
   assign if_n.req_i            = req;
   assign if_n.tail_i           = tail;
   assign if_n.out_ready_i      = ready;

   rr_grant_ctrl #(.PORTS(4), .ABORT_EN(1'b1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   rr_grant_ctrl #(.PORTS(4), .ABORT_EN(1'b0)) dut_n (
      .clk   (clk),
      .reset (reset),
      .bus   (if_n.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                        input logic chg, input logic bsy);
      chk({tag, ".grant"},  if_a.grant_o, g);
      chk({tag, ".id"},     {2'b00, if_a.grant_id_o}, {2'b00, id});
      chk({tag, ".change"}, {3'b000, if_a.change_order_o}, {3'b000, chg});
      chk({tag, ".busy"},   {3'b000, if_a.busy_o}, {3'b000, bsy});
   endtask

   // Ends the packet of port id with a tail transfer, then returns to IDLE.
   task automatic finish_pkt(input string tag, input logic [1:0] id);
      req   = 4'b0001 << id;
      tail  = 4'b0001 << id;
      ready = 1'b1;
      step();
      chk_a({tag, ".rel"}, 4'b0000, 2'd0, 1'b1, 1'b1);
      req   = 4'b0000;
      tail  = 4'b0000;
      ready = 1'b0;
      step();
      chk_a({tag, ".idle"}, 4'b0000, 2'd0, 1'b0, 1'b0);
   endtask

   initial begin
      exp_seq[0] = 4'b0100;
      exp_seq[1] = 4'b0010;
      exp_seq[2] = 4'b0001;
      exp_seq[3] = 4'b1000;
      exp_seq[4] = 4'b0100;

      #1;
      chk_a("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      reset = 1'b1;

      // Lock port 2, then reset mid-packet
      req  = 4'b1111;
      prio = 4'b0100;
      step();
      chk_a("arb_p2", 4'b0100, 2'd2, 1'b0, 1'b1);
      reset = 1'b0;
      #1;
      chk_a("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_a("rst_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
      reset = 1'b1;
      req  = 4'b0001;
      prio = 4'b0001;
      step();
      chk_a("post_rst", 4'b0001, 2'd0, 1'b0, 1'b1);
      finish_pkt("post_rst", 2'd0);

      req  = 4'b1111;
      prio = 4'b1000;
      step();
      chk_a("arb_p3", 4'b1000, 2'd3, 1'b0, 1'b1);
      finish_pkt("arb_p3", 2'd3);

      req  = 4'b0011;
      prio = 4'b1000;
      step();
      chk_a("wrap", 4'b0001, 2'd0, 1'b0, 1'b1);
      finish_pkt("wrap", 2'd0);

      req  = 4'b1010;
      prio = 4'b0000;
      step();
      chk_a("prio_zero", 4'b0010, 2'd1, 1'b0, 1'b1);
      finish_pkt("prio_zero", 2'd1);

      req  = 4'b1010;
      prio = 4'b0110;
      step();
      chk_a("prio_multi", 4'b0010, 2'd1, 1'b0, 1'b1);
      finish_pkt("prio_multi", 2'd1);

      // 3-flit packet on port 1 with ready 1,0,1,1
      req   = 4'b0010;
      prio  = 4'b0001;
      ready = 1'b0;
      step();
      chk_a("pkt3.lock0", 4'b0010, 2'd1, 1'b0, 1'b1);
      ready = 1'b1;
      tail  = 4'b0001;
      step();
      chk_a("pkt3.lock1", 4'b0010, 2'd1, 1'b0, 1'b1);
      ready = 1'b0;
      tail  = 4'b0000;
      step();
      chk_a("pkt3.lock2", 4'b0010, 2'd1, 1'b0, 1'b1);
      ready = 1'b1;
      step();
      chk_a("pkt3.lock3", 4'b0010, 2'd1, 1'b0, 1'b1);
      tail = 4'b0010;
      step();
      chk_a("pkt3.rel", 4'b0000, 2'd0, 1'b1, 1'b1);
      req   = 4'b0000;
      tail  = 4'b0000;
      ready = 1'b0;
      step();
      chk_a("pkt3.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Port 3 waits while port 0 is locked
      req  = 4'b0001;
      prio = 4'b0001;
      step();
      chk_a("wait.p0", 4'b0001, 2'd0, 1'b0, 1'b1);
      req = 4'b1001;
      step();
      chk_a("wait.hold1", 4'b0001, 2'd0, 1'b0, 1'b1);
      step();
      chk_a("wait.hold2", 4'b0001, 2'd0, 1'b0, 1'b1);
      tail  = 4'b0001;
      ready = 1'b1;
      step();
      chk_a("wait.rel", 4'b0000, 2'd0, 1'b1, 1'b1);
      req   = 4'b1000;
      tail  = 4'b0000;
      ready = 1'b0;
      step();
      chk_a("wait.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_a("wait.p3", 4'b1000, 2'd3, 1'b0, 1'b1);
      finish_pkt("wait.p3", 2'd3);

      // Rotating priority model, single-flit packets, all ports requesting
      prio       = 4'b0100;
      req        = 4'b1111;
      tail       = 4'b1111;
      ready      = 1'b1;
      prev_grant = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rot.grant", if_a.grant_o, exp_seq[k]);
         n_checks++;
         assert (if_a.grant_o !== prev_grant)
         else begin
            n_fail++;
            $error("FAIL rot.repeat: observed %b expected not %b", if_a.grant_o, prev_grant);
         end
         prev_grant = if_a.grant_o;
         step();
         chk("rot.change", {3'b000, if_a.change_order_o}, 4'b0001);
         if (if_a.change_order_o)
            prio = {prio[0], prio[3:1]};
         step();
         chk("rot.idle", {3'b000, if_a.change_order_o}, 4'b0000);
      end
      req   = 4'b0000;
      tail  = 4'b0000;
      ready = 1'b0;
      step();
      chk_a("rot.end", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Abort: granted port drops req before tail
      req  = 4'b0100;
      prio = 4'b0100;
      step();
      chk("abort.a.grant", if_a.grant_o, 4'b0100);
      chk("abort.n.grant", if_n.grant_o, 4'b0100);
      req   = 4'b0000;
      ready = 1'b1;
      step();
      chk_a("abort.a.rel", 4'b0000, 2'd0, 1'b1, 1'b1);
      chk("abort.n.hold", if_n.grant_o, 4'b0100);
      chk("abort.n.nochg", {3'b000, if_n.change_order_o}, 4'b0000);
      step();
      chk_a("abort.a.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      chk("abort.n.hold2", if_n.grant_o, 4'b0100);
      chk("abort.n.nochg2", {3'b000, if_n.change_order_o}, 4'b0000);
      chk("abort.n.busy", {3'b000, if_n.busy_o}, 4'b0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- 4-requester round-robin grant controller for a NOC output-port arbiter.
- Consumes the one-hot priority vector from the round-robin priority register and issues one grant per packet.
- Holds each grant until the tail flit transfers, then pulses `change_order_o` for one cycle so the priority register rotates.
- Sits between the input-port request lines and the output crossbar select.

Parameters:
- PORTS, 4, number of requesters; only 4 is supported.
- ABORT_EN, 1, when 1 a granted requester that drops `req` while locked releases the grant as if its tail had transferred.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- priority_order_i  input  4  one-hot highest-priority port from the priority register.
- req_i  input  4  per-port request; a port holds it high while it has a flit pending.
- tail_i  input  4  per-port flag marking the current flit as the packet tail.
- out_ready_i  input  1  downstream accepts a flit this cycle.
- grant_o  output  4  one-hot grant (crossbar select); all zero when nothing is granted.
- grant_id_o  output  2  binary index of the granted port; 0 when idle.
- change_order_o  output  1  one-cycle pulse telling the priority register to rotate.
- busy_o  output  1  high in the LOCK and RELEASE states.

Behaviour:
- All outputs are registered. `reset` low asynchronously forces state IDLE, `grant_o` = 0, `grant_id_o` = 0, `change_order_o` = 0, `busy_o` = 0. This holds mid-packet too; no pulse is generated.
- Priority index p is the set bit of `priority_order_i`. If the vector is not one-hot (zero or multiple bits), p = 0.
- Search order is p, p+1, p+2, p+3, mod 4. The winner is the first index with `req_i` high.
- Transfer (xfer) = `req_i[g]` & `out_ready_i` while in LOCK, where g = `grant_id_o`.

States:
- IDLE:
  - If `req_i` != 0, register winner w: `grant_o` = 1<<w, `grant_id_o` = w, go to LOCK. Grant is visible the cycle after the request is sampled (1-cycle latency).
  - Otherwise stay in IDLE.
- LOCK:
  - `grant_o` stays stable.
  - Other requesters are ignored.
  - xfer with `tail_i[g]` = 1: clear `grant_o`, set `change_order_o` = 1, go to RELEASE.
  - xfer with tail = 0: stay in LOCK.
  - `req_i[g]` = 0 with ABORT_EN = 1: same release path.
  - `req_i[g]` = 0 with ABORT_EN = 0: stay in LOCK.
  - `out_ready_i` = 0: hold the grant indefinitely.
- RELEASE (exactly one cycle):
  - `change_order_o` = 1, `grant_o` = 0.
  - No arbitration, because `priority_order_i` is stale until the register updates at the end of this cycle.
  - Next state is IDLE with `change_order_o` = 0.
- Minimum grant-to-grant spacing is 3 cycles (LOCK→RELEASE→IDLE→LOCK). A single-flit packet (tail on first flit) therefore occupies 3 cycles.
- `change_order_o` is never high for 2 consecutive cycles and never high outside RELEASE.
- Simultaneous requests arriving while a port is locked wait; they are evaluated only in IDLE.
- `tail_i` on non-granted ports is ignored.

Test Plan:
- Reset low mid-LOCK (`grant_o` = 0100) → all outputs 0 immediately, no `change_order_o` pulse. After release, `req_i` = 0001 with `priority_order_i` = 0001 → `grant_o` = 0001 one cycle later.
- `req_i` = 1111, `priority_order_i` = 0100 → `grant_o` = 0100, `grant_id_o` = 2.
  - With `priority_order_i` = 1000 → `grant_o` = 1000.
  - With `req_i` = 0011, `priority_order_i` = 1000 → `grant_o` = 0001 (wrap-around).
- 3-flit packet on port 1, `out_ready_i` toggling 1,0,1,1, tail on flit 3 → `grant_o` = 0010 for all 4 LOCK cycles. `change_order_o` pulses exactly once, in the cycle after the tail transfer, with `grant_o` = 0.
- Port 3 requests while port 0 is locked → port 3 not granted until after RELEASE. Feeding the rotated `priority_order_i` from a model of the priority register with `req_i` = 1111 continuously → grant sequence 2,1,0,3,2 from initial priority 0100, with no port granted twice in a row.
- ABORT_EN = 1, granted port drops `req` before tail → RELEASE with a single `change_order_o` pulse. With ABORT_EN = 0, same stimulus → grant held, no pulse.
- `priority_order_i` = 0000 or 0110 with `req_i` = 1010 → `grant_o` = 0010 (p treated as 0).
